kf_host_io_ctrl: RTL

// - Host-side front/back end for kf_top. Accepts KF load words (Phi, Q, R, x0, P0, y) on a valid/ready stream and buffers them.
// - Pulses START and presents one word per cycle on DATA_IN, aligned to the sequencer's PC0..PC(N_LOAD-1) load instructions.
// - Waits for kf_top READY, then reads result words back via DIR/DATA_OUT and emits them on an output valid/ready stream.

---
 rtl/kf_pkg.sv | 25 ++
 rtl/kf_word_buf.sv | 30 +++
 rtl/kf_host_io_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/kf_pkg.sv
// Shared KF parameters, widths and controller state encoding.
// Used by kf_top, the host I/O controller and the benches.
package kf_pkg;
   localparam int W       = 24;
   localparam int FRAC    = 14;
   localparam int ADDRW   = 5;
   localparam int N_LOAD  = 6;
   localparam int N_RD    = 2;
   localparam int RD_BASE = 0;
   localparam int RD_LAT  = 1;
   localparam int GUARD   = 4;
   localparam int TMO     = 1023;

   localparam int CW  = $clog2(N_LOAD + 1);
   localparam int RCW = $clog2(TMO + 1);
   localparam int RW  = (N_RD > 1) ? $clog2(N_RD) : 1;
   localparam int WW  = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

   typedef enum logic [1:0] {
      FILL,
      LOAD,
      RUN,
      READBACK
   } state_t;
endpackage

// File: rtl/kf_word_buf.sv
// N_LOAD-deep load-word register file with an internal write pointer.
// Reads past the last entry return zero.
module kf_word_buf
   import kf_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          we,
   input  logic [W-1:0]  wdata,
   input  logic [CW-1:0] ridx,
   output logic [CW-1:0] cnt,
   output logic [W-1:0]  rdata
);
   logic [W-1:0] mem [N_LOAD];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
         for (int i = 0; i < N_LOAD; i++) mem[i] <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (we) begin
         mem[cnt] <= wdata;
         cnt      <= cnt + CW'(1);
      end
   end

   assign rdata = (ridx < CW'(N_LOAD)) ? mem[ridx] : '0;
endmodule

// File: rtl/kf_host_io_ctrl.sv
// Host front/back end for kf_top: buffers load words, streams them
// after START, waits for READY and returns result words.
module kf_host_io_ctrl
   import kf_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   output logic             START,
   output logic [W-1:0]     DATA_IN,
   output logic [ADDRW-1:0] DIR,
   output logic             WRITE,
   input  logic             READY,
   input  logic [W-1:0]     DATA_OUT,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_data,
   output logic             busy,
   output logic             err
);
   state_t           state, state_d;
   logic [CW-1:0]    k, k_d;
   logic [RCW-1:0]   run_cnt, run_cnt_d;
   logic [RW-1:0]    r, r_d;
   logic [WW-1:0]    w, w_d;
   logic             start_d, out_valid_d, err_d;
   logic [W-1:0]     data_in_d, out_data_d;
   logic [ADDRW-1:0] dir_d;
   logic [CW-1:0]    cnt, rd_idx;
   logic [W-1:0]     rd_data;
   logic             buf_clr;

   kf_word_buf u_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (buf_clr),
      .we    (in_valid && in_ready),
      .wdata (in_data),
      .ridx  (rd_idx),
      .cnt   (cnt),
      .rdata (rd_data)
   );

   assign WRITE    = 1'b0;
   assign busy     = (state != FILL);
   assign in_ready = (state == FILL) && (cnt < CW'(N_LOAD));
   // Prefetch the word that DATA_IN must show on the following cycle.
   assign rd_idx   = (state == LOAD) ? k + CW'(1) : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= FILL;
         k         <= '0;
         run_cnt   <= '0;
         r         <= '0;
         w         <= '0;
         START     <= 1'b0;
         DATA_IN   <= '0;
         DIR       <= ADDRW'(RD_BASE);
         out_valid <= 1'b0;
         out_data  <= '0;
         err       <= 1'b0;
      end else begin
         state     <= state_d;
         k         <= k_d;
         run_cnt   <= run_cnt_d;
         r         <= r_d;
         w         <= w_d;
         START     <= start_d;
         DATA_IN   <= data_in_d;
         DIR       <= dir_d;
         out_valid <= out_valid_d;
         out_data  <= out_data_d;
         err       <= err_d;
      end
   end

   always_comb begin
      state_d     = state;
      k_d         = k;
      run_cnt_d   = run_cnt;
      r_d         = r;
      w_d         = w;
      start_d     = 1'b0;
      data_in_d   = DATA_IN;
      dir_d       = DIR;
      out_valid_d = out_valid;
      out_data_d  = out_data;
      err_d       = err;
      buf_clr     = 1'b0;
      unique case (state)
         FILL: begin
            if (cnt == CW'(N_LOAD) && en && !err) begin
               state_d   = LOAD;
               k_d       = '0;
               start_d   = 1'b1;
               data_in_d = rd_data;
            end
         end
         LOAD: begin
            if (k == CW'(N_LOAD - 1)) begin
               state_d   = RUN;
               data_in_d = '0;
               run_cnt_d = '0;
            end else begin
               k_d       = k + CW'(1);
               data_in_d = rd_data;
            end
         end
         RUN: begin
            if (run_cnt >= RCW'(GUARD) && READY) begin
               state_d = READBACK;
               r_d     = '0;
               w_d     = '0;
               dir_d   = ADDRW'(RD_BASE);
            end else if (run_cnt == RCW'(TMO - 1)) begin
               err_d   = 1'b1;
               state_d = FILL;
               buf_clr = 1'b1;
            end else begin
               run_cnt_d = run_cnt + RCW'(1);
            end
         end
         READBACK: begin
            if (!out_valid) begin
               if (w == WW'(RD_LAT)) begin
                  out_data_d  = DATA_OUT;
                  out_valid_d = 1'b1;
               end else begin
                  w_d = w + WW'(1);
               end
            end else if (out_ready) begin
               out_valid_d = 1'b0;
               w_d         = '0;
               if (r == RW'(N_RD - 1)) begin
                  state_d = FILL;
                  buf_clr = 1'b1;
                  dir_d   = ADDRW'(RD_BASE);
               end else begin
                  r_d   = r + RW'(1);
                  dir_d = DIR + ADDRW'(1);
               end
            end
         end
         default: ;
      endcase
   end
endmodule
